// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its IP register, instruction memory and decoder.
// master: the sequencer itself; slave: the surrounding environment.
`ifndef GR_SIZE
`define GR_SIZE 32
`endif

interface fetch_sequencer_if;
    logic        [`GR_SIZE-1:0] ipValue;
    logic signed [`GR_SIZE-1:0] ipAdjust;
    logic                       ipUpdateEnable;
    logic                       ipSetEnable;

    logic        [`GR_SIZE-1:0] memAddr;
    logic                       memReq;
    logic                       memAck;
    logic        [31:0]         memData;

    logic        [31:0]         instr;
    logic                       instrValid;
    logic                       instrReady;

    logic                       branchValid;
    logic                       branchRelative;
    logic signed [`GR_SIZE-1:0] branchTarget;

    logic                       fault;

    modport master (
        input  ipValue,
        output ipAdjust, ipUpdateEnable, ipSetEnable,
        output memAddr, memReq,
        input  memAck, memData,
        output instr, instrValid,
        input  instrReady,
        input  branchValid, branchRelative, branchTarget,
        output fault
    );

    modport slave (
        output ipValue,
        input  ipAdjust, ipUpdateEnable, ipSetEnable,
        input  memAddr, memReq,
        output memAck, memData,
        input  instr, instrValid,
        output instrReady,
        output branchValid, branchRelative, branchTarget,
        input  fault
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches at the IP, hands words to the decoder, steps or redirects the IP.
// Optional fetch watchdog with sticky fault enabled by defining FETCH_TIMEOUT_EN.
`ifndef GR_SIZE
`define GR_SIZE 32
`endif

module fetch_sequencer #(
    parameter int INSTR_BYTES   = 4,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                resetEnable,
    fetch_sequencer_if.master   bus
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, REQ, HOLD, STEP, FAULT} state_t;
    localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
`else
    typedef enum logic [1:0] {IDLE, REQ, HOLD, STEP} state_t;
`endif

    state_t                     state;
    logic signed [`GR_SIZE-1:0] ipAdjustQ;
    logic                       ipUpdateEnableQ;
    logic                       ipSetEnableQ;
    logic                       memReqQ;
    logic        [31:0]         instrQ;
    logic                       instrValidQ;
    logic                       redirect;

    // Redirects only count while the fetch loop is live; IDLE and FAULT ignore them.
    assign redirect = bus.branchValid &&
                      ((state == REQ) || (state == HOLD) || (state == STEP));

`ifdef FETCH_TIMEOUT_EN
    logic [CNT_W-1:0] waitCount;
    logic             faultQ;

    always_ff @(posedge clk) begin
        if (resetEnable) begin
            state           <= IDLE;
            ipAdjustQ       <= '0;
            ipUpdateEnableQ <= 1'b0;
            ipSetEnableQ    <= 1'b0;
            memReqQ         <= 1'b0;
            instrQ          <= '0;
            instrValidQ     <= 1'b0;
            waitCount       <= '0;
            faultQ          <= 1'b0;
        end else begin
            ipUpdateEnableQ <= 1'b0;
            ipSetEnableQ    <= 1'b0;
            if (redirect) begin
                instrValidQ     <= 1'b0;
                memReqQ         <= 1'b0;
                ipAdjustQ       <= bus.branchTarget;
                ipUpdateEnableQ <= bus.branchRelative;
                ipSetEnableQ    <= !bus.branchRelative;
                state           <= STEP;
            end else begin
                case (state)
                    IDLE: begin
                        memReqQ   <= 1'b1;
                        waitCount <= '0;
                        state     <= REQ;
                    end
                    REQ: begin
                        // An ack on the expiry cycle still completes the fetch.
                        if (bus.memAck) begin
                            instrQ      <= bus.memData;
                            instrValidQ <= 1'b1;
                            memReqQ     <= 1'b0;
                            state       <= HOLD;
                        end else if (waitCount == CNT_W'(FETCH_TIMEOUT - 1)) begin
                            memReqQ <= 1'b0;
                            faultQ  <= 1'b1;
                            state   <= FAULT;
                        end else begin
                            waitCount <= waitCount + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (bus.instrReady) begin
                            instrValidQ     <= 1'b0;
                            ipAdjustQ       <= `GR_SIZE'(INSTR_BYTES);
                            ipUpdateEnableQ <= 1'b1;
                            state           <= STEP;
                        end
                    end
                    STEP: begin
                        memReqQ   <= 1'b1;
                        waitCount <= '0;
                        state     <= REQ;
                    end
                    FAULT: begin
                        state <= FAULT;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.fault = faultQ;
`else
    always_ff @(posedge clk) begin
        if (resetEnable) begin
            state           <= IDLE;
            ipAdjustQ       <= '0;
            ipUpdateEnableQ <= 1'b0;
            ipSetEnableQ    <= 1'b0;
            memReqQ         <= 1'b0;
            instrQ          <= '0;
            instrValidQ     <= 1'b0;
        end else begin
            ipUpdateEnableQ <= 1'b0;
            ipSetEnableQ    <= 1'b0;
            if (redirect) begin
                instrValidQ     <= 1'b0;
                memReqQ         <= 1'b0;
                ipAdjustQ       <= bus.branchTarget;
                ipUpdateEnableQ <= bus.branchRelative;
                ipSetEnableQ    <= !bus.branchRelative;
                state           <= STEP;
            end else begin
                case (state)
                    IDLE: begin
                        memReqQ <= 1'b1;
                        state   <= REQ;
                    end
                    REQ: begin
                        if (bus.memAck) begin
                            instrQ      <= bus.memData;
                            instrValidQ <= 1'b1;
                            memReqQ     <= 1'b0;
                            state       <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (bus.instrReady) begin
                            instrValidQ     <= 1'b0;
                            ipAdjustQ       <= `GR_SIZE'(INSTR_BYTES);
                            ipUpdateEnableQ <= 1'b1;
                            state           <= STEP;
                        end
                    end
                    STEP: begin
                        memReqQ <= 1'b1;
                        state   <= REQ;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.fault = 1'b0;

    // The watchdog is absent here, so its limit only has to be sane.
    if (FETCH_TIMEOUT < 1) begin : g_badTimeout
        $error("fetch_sequencer: FETCH_TIMEOUT must be at least 1");
    end
`endif

    // The IP register is upstream and stable, so the address can follow it directly.
    assign bus.memAddr        = (state == REQ) ? bus.ipValue : '0;
    assign bus.memReq         = memReqQ;
    assign bus.ipAdjust       = ipAdjustQ;
    assign bus.ipUpdateEnable = ipUpdateEnableQ;
    assign bus.ipSetEnable    = ipSetEnableQ;
    assign bus.instr          = instrQ;
    assign bus.instrValid     = instrValidQ;

    enablesExclusive: assert property (@(posedge clk) !(ipUpdateEnableQ && ipSetEnableQ));

endmodule
